mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 15 +
 rtl/mem_resp_array.sv | 28 ++
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slave.
// Alignment checking is enabled by defining MEM_RESPONDER_ALIGN_CHECK_EN.
package mem_resp_pkg;

    localparam int MEM_WORD_W      = 32;
    localparam int WAIT_STATES_DEF = 1;
    localparam int WAIT_STATES_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: one synchronous write port,
// one read port sampled by the caller on its data-load edge.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [MEM_WORD_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [MEM_WORD_W-1:0] o_rdata
);

    logic [MEM_WORD_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Write-first: a store on the load edge is seen by that load.
    assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata
                                                      : r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory slave: level read handshake, single-cycle writes.
// Optional alignment checking under MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           mem_addr,
    input  logic [MEM_WORD_W-1:0] mem_write_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [MEM_WORD_W-1:0] mem_read_data,
    output logic                  mem_ready,
    output logic                  mem_err
);

    localparam logic [1:0] WS_INIT =
        (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    state_e                r_state;
    state_e                w_next;
    logic [1:0]            r_cnt;
    logic [1:0]            w_cnt_next;
    logic [ADDR_W-1:0]     r_idx;
    logic [MEM_WORD_W-1:0] r_rdata;
    logic                  r_ready;

    logic [ADDR_W-1:0]     w_idx;
    logic [ADDR_W-1:0]     w_raddr;
    logic [MEM_WORD_W-1:0] w_rdata;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_mis;
    logic                  w_we;
    logic                  w_unused;

    assign w_idx    = mem_addr[ADDR_W+1:2];
    assign w_unused = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign w_mis = (mem_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && mem_read && !mem_write;
    assign w_we     = reset && mem_write && !w_mis;
    assign w_raddr  = (r_state == ST_IDLE) ? w_idx : r_idx;

    mem_resp_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (mem_write_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_load     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_load = 1'b1;
                        w_next = ST_DATA;
                    end else begin
                        w_next     = ST_WAIT;
                        w_cnt_next = WS_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!mem_read) begin
                    w_next     = ST_IDLE;
                    w_cnt_next = 2'd0;
                end else if (r_cnt == 2'd0) begin
                    w_load = 1'b1;
                    w_next = ST_DATA;
                end else begin
                    w_cnt_next = r_cnt - 2'd1;
                end
            end
            ST_DATA: begin
                if (!mem_read) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ready <= (w_next == ST_DATA);
            if (w_accept) begin
                r_idx <= w_idx;
            end
            if (w_load) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign mem_read_data = r_rdata;
    assign mem_ready     = r_ready;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_mis && (mem_write || w_accept);
        end
    end

    assign mem_err = r_err;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, latency probes and random
// traffic against a reference model, on WAIT_STATES = 1, 0 and 3.
module tb_mem_responder;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdat [3];
    logic        rrdy [3];
    logic        rerr [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(10), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_read_data(rdat[0]),
        .mem_ready(rrdy[0]), .mem_err(rerr[0]));

    mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_read_data(rdat[1]),
        .mem_ready(rrdy[1]), .mem_err(rerr[1]));

    mem_responder #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_read_data(rdat[2]),
        .mem_ready(rrdy[2]), .mem_err(rerr[2]));

    // Reference model: one shared word array, per-instance read progress.
    int          ws   [3] = '{1, 0, 3};
    logic [31:0] m    [1024];
    bit          busy [3];
    bit          mrdy [3];
    bit          merr [3];
    int          age  [3];
    logic [9:0]  pidx [3];
    logic [31:0] mdat [3];

    task automatic model_edge();
        logic [9:0] idx;
        bit mis;
        idx = mem_addr[11:2];
        mis = ALIGN && (mem_addr[1:0] != 2'b00);
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                busy[k] = 0; mrdy[k] = 0; merr[k] = 0; mdat[k] = '0;
            end
        end else begin
            if (mem_write && !mis) m[idx] = mem_write_data;
            for (int k = 0; k < 3; k++) begin
                merr[k] = mis && mem_write;
                if (!busy[k]) begin
                    if (mem_read && !mem_write) begin
                        busy[k] = 1; age[k] = 0; pidx[k] = idx;
                        if (mis) merr[k] = 1;
                        if (ws[k] == 0) begin
                            mdat[k] = m[idx]; mrdy[k] = 1;
                        end
                    end
                end else if (!mrdy[k]) begin
                    if (!mem_read) busy[k] = 0;
                    else begin
                        age[k]++;
                        if (age[k] == ws[k]) begin
                            mdat[k] = m[pidx[k]]; mrdy[k] = 1;
                        end
                    end
                end else if (!mem_read) begin
                    busy[k] = 0; mrdy[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
        reset = rst; mem_read = rd; mem_write = wr;
        mem_addr = a; mem_write_data = d;
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("model_data", k, rdat[k], mdat[k]);
            chk("model_ready", k, 32'(rrdy[k]), 32'(mrdy[k]));
            chk("model_err", k, 32'(rerr[k]), 32'(merr[k]));
        end
    endtask

    typedef struct {
        bit          rst;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] ed;
        bit          er;
    } vec_t;

    function automatic vec_t v(bit rst, bit rd, bit wr, logic [31:0] a,
                               logic [31:0] d, logic [31:0] ed, bit er);
        vec_t t;
        t.rst = rst; t.rd = rd; t.wr = wr; t.addr = a;
        t.wd = d; t.ed = ed; t.er = er;
        return t;
    endfunction

    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] CF  = 32'hCAFEF00D;
    localparam logic [31:0] W40 = ALIGN ? DB : 32'h77;

    vec_t tbl[$];
    int   lat[3];
    logic [31:0] picks[5];
    bit   rd_r;

    initial begin
        reset = 0; mem_read = 0; mem_write = 0;
        mem_addr = 0; mem_write_data = 0;
        for (int k = 0; k < 3; k++) begin
            busy[k] = 0; mrdy[k] = 0; merr[k] = 0; age[k] = 0;
            pidx[k] = '0; mdat[k] = '0;
        end

        // expected values for the WAIT_STATES=1 instance
        tbl.push_back(v(0,0,0,32'h0,   0,            32'h0, 0));
        tbl.push_back(v(0,0,0,32'h0,   0,            32'h0, 0));
        tbl.push_back(v(1,0,1,32'h40,  DB,           32'h0, 0));
        tbl.push_back(v(1,0,1,32'h80,  32'h12345678, 32'h0, 0));
        tbl.push_back(v(1,0,1,32'h10,  32'hAAAA5555, 32'h0, 0));
        tbl.push_back(v(1,1,0,32'h40,  0,            32'h0, 0));
        tbl.push_back(v(1,1,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(1,1,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(1,0,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(1,1,0,32'h80,  0,            DB,    0));
        tbl.push_back(v(1,0,0,32'h80,  0,            DB,    0));
        tbl.push_back(v(1,0,0,32'h0,   0,            DB,    0));
        tbl.push_back(v(1,1,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(1,1,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(1,0,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(1,1,0,32'h10,  0,            DB,    0));
        tbl.push_back(v(1,1,1,32'h10,  32'h1,        32'h1, 0));
        tbl.push_back(v(1,0,0,32'h10,  0,            32'h1, 0));
        tbl.push_back(v(1,0,1,32'h1000,CF,           32'h1, 0));
        tbl.push_back(v(1,1,0,32'h0,   0,            32'h1, 0));
        tbl.push_back(v(1,1,0,32'h0,   0,            CF,    0));
        tbl.push_back(v(1,0,0,32'h0,   0,            CF,    0));
        tbl.push_back(v(1,1,0,32'h40,  0,            CF,    0));
        tbl.push_back(v(0,1,0,32'h40,  0,            32'h0, 0));
        tbl.push_back(v(1,1,0,32'h40,  0,            32'h0, 0));
        tbl.push_back(v(1,1,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(1,0,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(0,0,1,32'h40,  0,            32'h0, 0));
        tbl.push_back(v(1,1,0,32'h40,  0,            32'h0, 0));
        tbl.push_back(v(1,1,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(1,0,0,32'h40,  0,            DB,    0));
        tbl.push_back(v(1,1,1,32'h80,  32'h55,       DB,    0));
        tbl.push_back(v(1,1,0,32'h80,  0,            DB,    0));
        tbl.push_back(v(1,1,0,32'h80,  0,            32'h55,0));
        tbl.push_back(v(1,0,0,32'h80,  0,            32'h55,0));
        tbl.push_back(v(1,0,1,32'h42,  32'h77,       32'h55,ALIGN));
        tbl.push_back(v(1,1,0,32'h40,  0,            32'h55,0));
        tbl.push_back(v(1,1,0,32'h40,  0,            W40,   0));
        tbl.push_back(v(1,0,0,32'h40,  0,            W40,   0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
            chk($sformatf("tbl%0d_data", i), 0, rdat[0], tbl[i].ed);
            chk($sformatf("tbl%0d_ready", i), 0, 32'(rrdy[0]),
                32'(tbl[i].rd && tbl[i].rst && tbl[i].ed == rdat[0]
                    && (i == 6 || i == 7 || i == 13 || i == 16
                        || i == 20 || i == 25 || i == 29 || i == 33
                        || i == 37)));
            chk($sformatf("tbl%0d_err", i), 0, 32'(rerr[0]), 32'(tbl[i].er));
        end

        // load latency per instance, counted in edges from mem_read rising
        step(1, 0, 0, 32'h40, 0);
        for (int k = 0; k < 3; k++) lat[k] = 0;
        for (int c = 1; c <= 6; c++) begin
            step(1, 1, 0, 32'h40, 0);
            for (int k = 0; k < 3; k++)
                if (lat[k] == 0 && rrdy[k]) lat[k] = c;
        end
        chk("latency_ws1", 0, 32'(lat[0]), 32'd2);
        chk("latency_ws0", 1, 32'(lat[1]), 32'd1);
        chk("latency_ws3", 2, 32'(lat[2]), 32'd4);
        step(1, 0, 0, 32'h40, 0);

        // random traffic over words already written above
        picks[0] = 32'h0;  picks[1] = 32'h10; picks[2] = 32'h40;
        picks[3] = 32'h80; picks[4] = 32'h1000;
        rd_r = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) rd_r = !rd_r;
            step(($urandom_range(63) != 0), rd_r,
                 ($urandom_range(3) == 0),
                 picks[$urandom_range(4)] | 32'($urandom_range(3)),
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
